fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch buffer between the fetch PC logic and the decode stage of the core.
- Issues sequential word addresses to the synchronous instruction memory and captures the returned instructions with their original addresses.
- Holds fetched instructions in a small FIFO so that decode stalls never drop or duplicate an instruction.
- On a taken branch from execute, discards all queued and in-flight fetches and redirects the PC.

Parameters:
- ADDR_W, 16, width of instruction addresses (word-addressed).
- INST_W, 16, instruction width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 3.
- RESET_ADDR, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- branch_i  in  1  taken-branch redirect from execute.
- baddr_i  in  ADDR_W  branch target; valid when branch_i=1.
- stall_i  in  1  decode cannot accept this cycle.
- req_o  out  1  instruction-memory read enable.
- addr_o  out  ADDR_W  instruction-memory read address (current PC).
- inst_i  in  INST_W  instruction-memory read data; valid the cycle after req_o=1.
- v_o  out  1  inst_o/origaddr_o hold a valid instruction.
- inst_o  out  INST_W  head-of-queue instruction.
- origaddr_o  out  ADDR_W  address the head instruction was fetched from.
- count_o  out  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- State: pc; inflight flag; inflight_addr; FIFO with rd_ptr, wr_ptr and count.
- Reset (async, takes effect immediately): pc=RESET_ADDR, inflight=0, pointers=0, count=0.
  - Outputs during and after reset: req_o=0, v_o=0, count_o=0, addr_o=RESET_ADDR, inst_o and origaddr_o=0.
- Fetch issue (combinational from registered state):
  - req_o = ~branch_i & ~rst & (count + inflight < DEPTH).
  - addr_o = pc.
  - On an edge with req_o=1: pc <= pc+1, wrapping modulo 2^ADDR_W; inflight <= 1; inflight_addr <= pc.
  - On an edge with req_o=0: inflight <= 0.
- Capture: on an edge where inflight=1 and branch_i=0, {inst_i, inflight_addr} is written at wr_ptr.
  - The credit rule guarantees free space, so an overflow condition is unreachable.
  - A bench assertion must flag any push when count == DEPTH.
- Output: v_o = (count != 0) & ~branch_i.
  - inst_o and origaddr_o come from the rd_ptr entry; they are 0 when count == 0.
- Pop: on an edge where v_o=1 and stall_i=0, rd_ptr advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: fetch request at cycle N, instruction written at edge N+1, v_o=1 from cycle N+2. There is no bypass path.
- Throughput: one instruction per cycle in steady state with no stall.
- Branch, branch_i=1 in cycle B (priority over push, pop and stall):
  - In cycle B: v_o=0, req_o=0; the response arriving in cycle B is discarded.
  - At the edge ending B: count=0, rd_ptr=wr_ptr=0, inflight=0, pc <= baddr_i.
  - Cycle B+1: req_o=1 with addr_o=baddr_i. Cycle B+3: v_o=1 with origaddr_o=baddr_i.
- Stall held indefinitely: the queue fills to DEPTH, req_o drops to 0, and head outputs stay stable.
- Back-to-back branches: the last one wins and each restarts the sequence above.

Decomposition:
- Shared header include/params.vh holds ADDR_W, INST_W, RESET_ADDR and the fetch queue DEPTH default.
- One natural sub-module: fetch_fifo.
  - Parametrised storage of {origaddr, inst}.
  - Provides push, pop, flush, count and head outputs.
- fetch_queue itself keeps the PC, inflight tracking, credit check and branch priority.

Test Plan:
- Sequential fetch: release reset, stall_i=0, memory returns inst = addr^16'hA5A5 → req_o at 0000,0001,...; v_o from cycle 2; origaddr_o 0000,0001,0002 on consecutive cycles; inst_o 0x5A5A? no → inst_o = addr^A5A5 (0000→A5A5, 0001→A5A4).
- Stall fill: stall_i=1 for 8 cycles → count_o reaches 4, req_o=0, head origaddr_o stays 0000; release → origaddr_o 0000..0003 then 0004 with no gap or duplicate.
- Branch flush: queue holds 3 entries plus one inflight, branch_i=1 with baddr_i=0040 → v_o=0 for cycles B..B+2, addr_o=0040 at B+1, origaddr_o 0040 at B+3, then 0041; no pre-branch address is ever emitted.
- Branch while stalled and full: stall_i=1, count_o=4, branch to 0100 → count_o=0 after the edge; origaddr_o=0100 at B+3 once stall_i is released.
- PC wrap: branch to FFFF, no stall → origaddr_o FFFF then 0000.
- Async reset mid-run: assert rst 3ns after an edge with count_o=2 → v_o, req_o and count_o go to 0 before the next edge; after release, fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue_pkg : shared widths and defaults for the fetch queue   |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
package fetch_queue_pkg;

   localparam int unsigned c_ADDR_W     = 16;
   localparam int unsigned c_INST_W     = 16;
   localparam int unsigned c_DEPTH      = 4;
   localparam int unsigned c_RESET_ADDR = 0;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue_if : memory, decode and branch signals of fetch_queue  |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = c_ADDR_W,
   parameter int unsigned INST_W = c_INST_W,
   parameter int unsigned DEPTH  = c_DEPTH
);
   localparam int unsigned c_CNT_W = cnt_width(DEPTH);

   logic                branch_i;
   logic [ADDR_W-1:0]   baddr_i;
   logic                stall_i;
   logic                req_o;
   logic [ADDR_W-1:0]   addr_o;
   logic [INST_W-1:0]   inst_i;
   logic                v_o;
   logic [INST_W-1:0]   inst_o;
   logic [ADDR_W-1:0]   origaddr_o;
   logic [c_CNT_W-1:0]  count_o;

   modport master (
      input  branch_i, baddr_i, stall_i, inst_i,
      output req_o, addr_o, v_o, inst_o, origaddr_o, count_o
   );

   modport slave (
      output branch_i, baddr_i, stall_i, inst_i,
      input  req_o, addr_o, v_o, inst_o, origaddr_o, count_o
   );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : circular buffer of {origaddr, inst} with flush        |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = c_ADDR_W,
   parameter int unsigned INST_W = c_INST_W,
   parameter int unsigned DEPTH  = c_DEPTH
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic                         push_i,
   input  wire logic                         pop_i,
   input  wire logic                         flush_i,
   input  wire logic [ADDR_W-1:0]            addr_i,
   input  wire logic [INST_W-1:0]            inst_i,
   output      logic [cnt_width(DEPTH)-1:0]  count_o,
   output      logic [ADDR_W-1:0]            head_addr_o,
   output      logic [INST_W-1:0]            head_inst_o
);
   localparam int unsigned c_PTR_W   = $clog2(DEPTH);
   localparam int unsigned c_CNT_W   = cnt_width(DEPTH);
   localparam int unsigned c_ENTRY_W = ADDR_W + INST_W;

   logic [c_ENTRY_W-1:0] mem_q [DEPTH];
   logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [c_CNT_W-1:0]   count_q, count_d;
   logic [c_ENTRY_W-1:0] w_head;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= {addr_i, inst_i};
   end

   assign w_head      = mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign head_addr_o = (count_q != '0) ? w_head[c_ENTRY_W-1:INST_W] : '0;
   assign head_inst_o = (count_q != '0) ? w_head[INST_W-1:0]         : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : PC sequencing, credit-based fetch and branch flush   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned       ADDR_W     = c_ADDR_W,
   parameter int unsigned       INST_W     = c_INST_W,
   parameter int unsigned       DEPTH      = c_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(c_RESET_ADDR)
) (
   input  wire logic       clk,
   input  wire logic       rst,
   fetch_queue_if.master   bus
);
   localparam int unsigned c_CNT_W = cnt_width(DEPTH);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
   logic               inflight_q, inflight_d;
   logic [c_CNT_W-1:0] w_count;
   logic [c_CNT_W:0]   w_outstanding;
   logic               w_req, w_push, w_pop, w_v;

   // Entries already queued plus the one in flight must fit, so a capture never overflows.
   assign w_outstanding = {1'b0, w_count} + (c_CNT_W+1)'(inflight_q);
   assign w_req  = ~bus.branch_i & ~rst & (w_outstanding < (c_CNT_W+1)'(DEPTH));
   assign w_push = inflight_q & ~bus.branch_i;
   assign w_v    = (w_count != '0) & ~bus.branch_i;
   assign w_pop  = w_v & ~bus.stall_i;

   always_comb begin
      pc_d            = pc_q;
      inflight_d      = w_req;
      inflight_addr_d = inflight_addr_q;
      if (bus.branch_i) begin
         pc_d = bus.baddr_i;
      end else if (w_req) begin
         pc_d            = pc_q + ADDR_W'(1);
         inflight_addr_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q            <= RESET_ADDR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         pc_q            <= pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end

   fetch_fifo #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .pop_i       (w_pop),
      .flush_i     (bus.branch_i),
      .addr_i      (inflight_addr_q),
      .inst_i      (bus.inst_i),
      .count_o     (w_count),
      .head_addr_o (bus.origaddr_o),
      .head_inst_o (bus.inst_o)
   );

   assign bus.req_o   = w_req;
   assign bus.addr_o  = pc_q;
   assign bus.v_o     = w_v;
   assign bus.count_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_queue : directed + random stimulus against a stream model |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fetch_queue_if #(.ADDR_W(16), .INST_W(16), .DEPTH(DEPTH)) fq_if ();

   fetch_queue #(
      .ADDR_W     (16),
      .INST_W     (16),
      .DEPTH      (DEPTH),
      .RESET_ADDR (16'h0000)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (fq_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: every fetch issued in cycle c becomes visible at the head from cycle c+2;
   // outstanding fetches (issued, not yet consumed) never exceed DEPTH.
   typedef struct {
      logic [15:0] addr;
      int          cyc;
   } item_t;

   item_t       fq[$];
   int          cyc;
   logic [15:0] exp_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic b, input logic [15:0] ba, input logic s);
      int          n_cap;
      logic        e_req;
      logic        e_v;
      logic        p_req;
      logic [15:0] p_addr;
      fq_if.branch_i = b;
      fq_if.baddr_i  = ba;
      fq_if.stall_i  = s;
      @(negedge clk);
      n_cap = 0;
      foreach (fq[i]) if (fq[i].cyc <= cyc - 2) n_cap++;
      e_req = !b && !rst && (fq.size() < DEPTH);
      e_v   = !b && (n_cap > 0);
      chk("req_o",   32'(fq_if.req_o),   32'(e_req));
      chk("addr_o",  32'(fq_if.addr_o),  32'(exp_pc));
      chk("v_o",     32'(fq_if.v_o),     32'(e_v));
      chk("count_o", 32'(fq_if.count_o), 32'(n_cap));
      if (n_cap > 0) begin
         chk("origaddr_o", 32'(fq_if.origaddr_o), 32'(fq[0].addr));
         chk("inst_o",     32'(fq_if.inst_o),     32'(fq[0].addr ^ 16'hA5A5));
      end else begin
         chk("origaddr_o_empty", 32'(fq_if.origaddr_o), 32'h0);
         chk("inst_o_empty",     32'(fq_if.inst_o),     32'h0);
      end
      chk("push_when_full", 32'(u_dut.w_push && (u_dut.w_count == 3'(DEPTH))), 32'h0);
      p_req  = fq_if.req_o;
      p_addr = fq_if.addr_o;
      @(posedge clk);
      if (rst) begin
         fq.delete();
         exp_pc = 16'h0000;
      end else if (b) begin
         fq.delete();
         exp_pc = ba;
      end else begin
         if (e_v && !s) void'(fq.pop_front());
         if (e_req) begin
            fq.push_back('{addr: exp_pc, cyc: cyc});
            exp_pc = exp_pc + 16'h1;
         end
      end
      cyc++;
      #1;
      fq_if.inst_i = p_req ? (p_addr ^ 16'hA5A5) : 16'($urandom);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      cyc            = 0;
      exp_pc         = 16'h0000;
      rst            = 1'b1;
      fq_if.branch_i = 1'b0;
      fq_if.baddr_i  = '0;
      fq_if.stall_i  = 1'b0;
      fq_if.inst_i   = '0;

      // Reset state
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      rst = 1'b0;

      // Sequential fetch
      for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, 1'b0);

      // Stall fill, then release
      for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b0);

      // Branch flush with a partly filled queue and a fetch in flight
      for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b1, 16'h0040, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b0);

      // Branch while stalled and full
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b1, 16'h0100, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b0);

      // PC wrap and back-to-back branches
      cycle(1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b1, 16'h1234, 1'b0);
      cycle(1'b1, 16'hFFFE, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic        rb;
         logic        rs;
         logic [15:0] ra;
         rb = ($urandom_range(15) == 0);
         rs = ($urandom_range(2) == 0);
         ra = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFFC)) : 16'($urandom);
         cycle(rb, ra, rs);
      end

      // Asynchronous reset with two entries queued
      cycle(1'b1, 16'h0200, 1'b0);
      for (int i = 0; i < 10 && fq_if.count_o != 3'd2; i++) cycle(1'b0, 16'h0, 1'b1);
      chk("wait_count2", 32'(fq_if.count_o), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("async_req_o",   32'(fq_if.req_o),   32'h0);
      chk("async_v_o",     32'(fq_if.v_o),     32'h0);
      chk("async_count_o", 32'(fq_if.count_o), 32'h0);
      chk("async_addr_o",  32'(fq_if.addr_o),  32'h0);
      fq.delete();
      exp_pc = 16'h0000;
      fq_if.stall_i = 1'b0;
      #2;
      cycle(1'b0, 16'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
